// File: rtl/pp_col_alu_pkg.sv
// Shared types, defaults and helpers for the pp_col_alu column datapath.
package pp_pkg;

    localparam int PP_NUM_SIZE = 32;
    localparam int PP_CNT_SIZE = 32;

    // Command encodings; codes 7 and 12..15 are illegal.
    typedef enum logic [3:0] {
        NOOP  = 4'd0,
        ADD   = 4'd1,
        SUB   = 4'd2,
        MIN   = 4'd3,
        MAX   = 4'd4,
        EQ    = 4'd5,
        LT    = 4'd6,
        SUM   = 4'd8,
        RMIN  = 4'd9,
        RMAX  = 4'd10,
        COUNT = 4'd11
    } pp_cmd_e;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_REDUCE = 1'b1
    } pp_state_e;

    // True for the whole-column commands.
    function automatic logic is_reduction(input logic [3:0] cmd);
        case (cmd)
            SUM, RMIN, RMAX, COUNT: return 1'b1;
            default:                return 1'b0;
        endcase
    endfunction

    // True for every defined command encoding.
    function automatic logic is_legal(input logic [3:0] cmd);
        case (cmd)
            NOOP, ADD, SUB, MIN, MAX, EQ, LT,
            SUM, RMIN, RMAX, COUNT: return 1'b1;
            default:                return 1'b0;
        endcase
    endfunction

    // Largest signed value of the given width, in the low bits of a 64-bit word.
    function automatic logic [63:0] sat_max(input int width);
        logic [63:0] r;
        r = 64'd0;
        for (int i = 0; i < 64; i++) begin
            if (i < width - 1) r[i] = 1'b1;
            else               r[i] = 1'b0;
        end
        return r;
    endfunction

    // Smallest signed value of the given width, in the low bits of a 64-bit word.
    function automatic logic [63:0] sat_min(input int width);
        logic [63:0] r;
        r = 64'd0;
        for (int i = 0; i < 64; i++) begin
            if (i == width - 1) r[i] = 1'b1;
            else                r[i] = 1'b0;
        end
        return r;
    endfunction

endpackage

// File: rtl/pp_col_alu_if.sv
// Valid/ready stream bundle between the column reader, pp_col_alu and the result writer.
// cmd is carried as raw 4 bits so illegal encodings can reach the block.
interface pp_col_alu_if
    import pp_pkg::*;
#(
    parameter int NUM_SIZE = PP_NUM_SIZE
) ();
    logic                       in_valid;
    logic                       in_ready;
    logic [3:0]                 cmd;
    logic signed [NUM_SIZE-1:0] in1;
    logic signed [NUM_SIZE-1:0] in2;
    logic                       in_last;
    logic                       out_valid;
    logic                       out_ready;
    logic signed [NUM_SIZE-1:0] out1;
    logic                       out_ovf;
    logic                       out_err;

    modport master (
        output in_valid, cmd, in1, in2, in_last, out_ready,
        input  in_ready, out_valid, out1, out_ovf, out_err
    );

    modport slave (
        input  in_valid, cmd, in1, in2, in_last, out_ready,
        output in_ready, out_valid, out1, out_ovf, out_err
    );
endinterface

// File: rtl/pp_col_alu_sat_addsub.sv
// Combinational saturating signed add/subtract, shared by ADD, SUB and SUM.
module pp_sat_addsub
    import pp_pkg::*;
#(
    parameter int NUM_SIZE = PP_NUM_SIZE
) (
    input  logic signed [NUM_SIZE-1:0] a_i,
    input  logic signed [NUM_SIZE-1:0] b_i,
    input  logic                       sub_i,
    output logic signed [NUM_SIZE-1:0] res_o,
    output logic                       ovf_o
);
    localparam logic [63:0] MAX_W = sat_max(NUM_SIZE);
    localparam logic [63:0] MIN_W = sat_min(NUM_SIZE);
    localparam logic signed [NUM_SIZE-1:0] SAT_MAX = MAX_W[NUM_SIZE-1:0];
    localparam logic signed [NUM_SIZE-1:0] SAT_MIN = MIN_W[NUM_SIZE-1:0];

    logic [NUM_SIZE:0] a_ext_s;
    logic [NUM_SIZE:0] b_ext_s;
    logic [NUM_SIZE:0] wide_s;

    assign a_ext_s = {a_i[NUM_SIZE-1], a_i};
    assign b_ext_s = {b_i[NUM_SIZE-1], b_i};

    // Exact result at one extra bit, then clamp when the top two bits disagree.
    always_comb begin
        if (sub_i) begin
            wide_s = a_ext_s - b_ext_s;
        end else begin
            wide_s = a_ext_s + b_ext_s;
        end
        if (wide_s[NUM_SIZE] != wide_s[NUM_SIZE-1]) begin
            ovf_o = 1'b1;
            if (wide_s[NUM_SIZE]) begin
                res_o = SAT_MIN;
            end else begin
                res_o = SAT_MAX;
            end
        end else begin
            ovf_o = 1'b0;
            res_o = wide_s[NUM_SIZE-1:0];
        end
    end
endmodule

// File: rtl/pp_col_alu.sv
// Column ALU: element-wise signed ops and whole-column reductions under valid/ready.
module pp_col_alu
    import pp_pkg::*;
#(
    parameter int NUM_SIZE = PP_NUM_SIZE,
    parameter int CNT_SIZE = PP_CNT_SIZE
) (
    input  logic         clk,
    input  logic         reset,
    pp_col_alu_if.slave  bus
);
    localparam logic [CNT_SIZE-1:0] CNT_ONE = {{(CNT_SIZE-1){1'b0}}, 1'b1};

    pp_state_e                  state_q, state_d;
    logic [3:0]                 red_cmd_q, red_cmd_d;
    logic signed [NUM_SIZE-1:0] acc_q, acc_d;
    logic [CNT_SIZE-1:0]        cnt_q, cnt_d;
    logic                       sticky_q, sticky_d;
    logic                       rdy_en_q;
    logic                       out_valid_q, out_valid_d;
    logic signed [NUM_SIZE-1:0] out1_q, out1_d;
    logic                       out_ovf_q, out_ovf_d;
    logic                       out_err_q, out_err_d;

    logic signed [NUM_SIZE-1:0] in1_s, in2_s;
    logic                       accept_s;
    logic signed [NUM_SIZE-1:0] as_a_s, as_b_s, as_res_s;
    logic                       as_sub_s, as_ovf_s;
    logic signed [NUM_SIZE-1:0] ew_res_s;
    logic                       ew_ovf_s;
    logic signed [NUM_SIZE-1:0] fold_s;
    logic                       fold_ovf_s;
    logic [CNT_SIZE-1:0]        cnt_inc_s, cnt_res_s;
    logic [NUM_SIZE-1:0]        cnt_ext_s;

    assign in1_s    = bus.in1;
    assign in2_s    = bus.in2;
    assign bus.in_ready = rdy_en_q && (!out_valid_q || bus.out_ready);
    assign accept_s = bus.in_valid && bus.in_ready;

    assign bus.out_valid = out_valid_q;
    assign bus.out1      = out1_q;
    assign bus.out_ovf   = out_ovf_q;
    assign bus.out_err   = out_err_q;

    // While reducing, the adder folds the next element into the running total.
    always_comb begin
        if (state_q == ST_REDUCE) begin
            as_a_s   = acc_q;
            as_b_s   = in1_s;
            as_sub_s = 1'b0;
        end else begin
            as_a_s   = in1_s;
            as_b_s   = in2_s;
            as_sub_s = (bus.cmd == SUB);
        end
    end

    pp_sat_addsub #(.NUM_SIZE(NUM_SIZE)) u_addsub (
        .a_i   (as_a_s),
        .b_i   (as_b_s),
        .sub_i (as_sub_s),
        .res_o (as_res_s),
        .ovf_o (as_ovf_s)
    );

    // Element-wise result for the current beat.
    always_comb begin
        ew_res_s = '0;
        ew_ovf_s = 1'b0;
        case (bus.cmd)
            NOOP:     ew_res_s = in1_s;
            ADD, SUB: begin
                ew_res_s = as_res_s;
                ew_ovf_s = as_ovf_s;
            end
            MIN:      ew_res_s = (in1_s < in2_s) ? in1_s : in2_s;
            MAX:      ew_res_s = (in1_s > in2_s) ? in1_s : in2_s;
            EQ:       ew_res_s[0] = (in1_s == in2_s);
            LT:       ew_res_s[0] = (in1_s < in2_s);
            default:  ew_res_s = '0;
        endcase
    end

    // Accumulator and counter values after folding in the current beat.
    always_comb begin
        fold_s     = acc_q;
        fold_ovf_s = sticky_q;
        case (red_cmd_q)
            SUM: begin
                fold_s     = as_res_s;
                fold_ovf_s = sticky_q | as_ovf_s;
            end
            RMIN:    fold_s = (in1_s < acc_q) ? in1_s : acc_q;
            RMAX:    fold_s = (in1_s > acc_q) ? in1_s : acc_q;
            default: fold_s = acc_q;
        endcase
        if (&cnt_q) begin
            cnt_inc_s = cnt_q;
        end else begin
            cnt_inc_s = cnt_q + CNT_ONE;
        end
        if (state_q == ST_IDLE) begin
            cnt_res_s = CNT_ONE;
        end else begin
            cnt_res_s = cnt_inc_s;
        end
    end

    // COUNT result is the element count resized to the data width.
    generate
        if (CNT_SIZE >= NUM_SIZE) begin : g_cnt_trunc
            assign cnt_ext_s = cnt_res_s[NUM_SIZE-1:0];
        end else begin : g_cnt_zext
            assign cnt_ext_s = {{(NUM_SIZE-CNT_SIZE){1'b0}}, cnt_res_s};
        end
    endgenerate

    // FSM next state, reduction bookkeeping and next output register contents.
    always_comb begin
        state_d     = state_q;
        red_cmd_d   = red_cmd_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        sticky_d    = sticky_q;
        out1_d      = out1_q;
        out_ovf_d   = out_ovf_q;
        out_err_d   = out_err_q;
        if (bus.out_ready) begin
            out_valid_d = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end

        if (accept_s) begin
            if (!is_legal(bus.cmd) || (state_q == ST_REDUCE && bus.cmd != red_cmd_q)) begin
                // Illegal command or a command switch mid-column: error beat, drop the column.
                out_valid_d = 1'b1;
                out1_d      = '0;
                out_ovf_d   = 1'b0;
                out_err_d   = 1'b1;
                state_d     = ST_IDLE;
                acc_d       = '0;
                cnt_d       = '0;
                sticky_d    = 1'b0;
            end else if (state_q == ST_IDLE) begin
                if (!is_reduction(bus.cmd)) begin
                    out_valid_d = 1'b1;
                    out1_d      = ew_res_s;
                    out_ovf_d   = ew_ovf_s;
                    out_err_d   = 1'b0;
                end else if (bus.in_last) begin
                    out_valid_d = 1'b1;
                    out_ovf_d   = 1'b0;
                    out_err_d   = 1'b0;
                    if (bus.cmd == COUNT) begin
                        out1_d = cnt_ext_s;
                    end else begin
                        out1_d = in1_s;
                    end
                end else begin
                    state_d   = ST_REDUCE;
                    red_cmd_d = bus.cmd;
                    acc_d     = in1_s;
                    cnt_d     = CNT_ONE;
                    sticky_d  = 1'b0;
                end
            end else if (bus.in_last) begin
                out_valid_d = 1'b1;
                out_err_d   = 1'b0;
                if (red_cmd_q == COUNT) begin
                    out1_d    = cnt_ext_s;
                    out_ovf_d = 1'b0;
                end else begin
                    out1_d    = fold_s;
                    out_ovf_d = fold_ovf_s;
                end
                state_d  = ST_IDLE;
                acc_d    = '0;
                cnt_d    = '0;
                sticky_d = 1'b0;
            end else begin
                acc_d    = fold_s;
                cnt_d    = cnt_inc_s;
                sticky_d = fold_ovf_s;
            end
        end else begin
            state_d = state_q;
        end
    end

    // State, reduction and output registers; reset discards any partial column.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            red_cmd_q   <= 4'd0;
            acc_q       <= '0;
            cnt_q       <= '0;
            sticky_q    <= 1'b0;
            rdy_en_q    <= 1'b0;
            out_valid_q <= 1'b0;
            out1_q      <= '0;
            out_ovf_q   <= 1'b0;
            out_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            red_cmd_q   <= red_cmd_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            sticky_q    <= sticky_d;
            rdy_en_q    <= 1'b1;
            out_valid_q <= out_valid_d;
            out1_q      <= out1_d;
            out_ovf_q   <= out_ovf_d;
            out_err_q   <= out_err_d;
        end
    end
endmodule

// File: tb/tb_pp_col_alu.sv
// Self-checking bench for pp_col_alu at NUM_SIZE=8, CNT_SIZE=4.
module tb_pp_col_alu;
    import pp_pkg::*;

    localparam int N       = 8;
    localparam int C       = 4;
    localparam int CNT_MAX = 15;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    pp_col_alu_if #(.NUM_SIZE(N)) bus ();

    pp_col_alu #(.NUM_SIZE(N), .CNT_SIZE(C)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // ---------------- reference model ----------------
    function automatic int clamp8(input int v, output bit o);
        o = 1'b0;
        if (v > 127)  begin o = 1'b1; return 127;  end
        if (v < -128) begin o = 1'b1; return -128; end
        return v;
    endfunction

    // Result of one beat presented to an idle block (reductions with in_last=1).
    function automatic void ref_single(input logic [3:0] c, input int a, input int b,
                                       output int r, output bit o, output bit e);
        o = 1'b0; e = 1'b0; r = 0;
        case (c)
            4'd0:  r = a;
            4'd1:  r = clamp8(a + b, o);
            4'd2:  r = clamp8(a - b, o);
            4'd3:  r = (a < b) ? a : b;
            4'd4:  r = (a > b) ? a : b;
            4'd5:  r = (a == b) ? 1 : 0;
            4'd6:  r = (a < b) ? 1 : 0;
            4'd8, 4'd9, 4'd10: r = a;
            4'd11: r = 1;
            default: e = 1'b1;
        endcase
    endfunction

    function automatic void ref_column(input logic [3:0] c, input int q[$],
                                       output int r, output bit o);
        bit t;
        o = 1'b0;
        r = q[0];
        for (int i = 1; i < q.size(); i++) begin
            case (c)
                4'd8:  begin r = clamp8(r + q[i], t); o = o | t; end
                4'd9:  r = (q[i] < r) ? q[i] : r;
                4'd10: r = (q[i] > r) ? q[i] : r;
                default: r = r;
            endcase
        end
        if (c == 4'd11) r = (q.size() > CNT_MAX) ? CNT_MAX : q.size();
    endfunction

    // ---------------- check helpers ----------------
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic expect_res(input string tag, input int exp, input bit o, input bit e);
        logic [7:0] e8;
        e8 = exp[7:0];
        chk({tag, ".valid"}, {31'd0, bus.out_valid}, 32'd1);
        chk({tag, ".out1"},  {24'd0, bus.out1}, {24'd0, e8});
        chk({tag, ".ovf"},   {31'd0, bus.out_ovf}, {31'd0, o});
        chk({tag, ".err"},   {31'd0, bus.out_err}, {31'd0, e});
    endtask

    task automatic expect_none(input string tag);
        chk({tag, ".novalid"}, {31'd0, bus.out_valid}, 32'd0);
    endtask

    // Present one beat at a negedge, wait (bounded) for acceptance, return at the next negedge.
    task automatic beat(input logic [3:0] c, input int a, input int b, input logic last);
        int guard;
        guard = 0;
        bus.cmd     = c;
        bus.in1     = a[7:0];
        bus.in2     = b[7:0];
        bus.in_last = last;
        bus.in_valid = 1'b1;
        while (bus.in_ready !== 1'b1 && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        chk("accept_wait", {31'd0, bus.in_ready}, 32'd1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic column(input string tag, input logic [3:0] c, input int q[$]);
        int r;
        bit o;
        for (int i = 0; i < q.size(); i++) begin
            beat(c, q[i], $urandom_range(0, 255), (i == q.size() - 1));
            if (i != q.size() - 1) expect_none(tag);
        end
        ref_column(c, q, r, o);
        expect_res(tag, r, o, 1'b0);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    // ---------------- stimulus ----------------
    initial begin
        int q[$];
        int r, a, b;
        bit o, e;
        logic [3:0] c;

        reset = 1'b0;
        bus.in_valid = 1'b0; bus.cmd = 4'd0; bus.in1 = '0; bus.in2 = '0;
        bus.in_last = 1'b0; bus.out_ready = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst.in_ready",  {31'd0, bus.in_ready}, 32'd0);
        chk("rst.out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("rst.out1",      {24'd0, bus.out1}, 32'd0);
        chk("rst.ovf",       {31'd0, bus.out_ovf}, 32'd0);
        chk("rst.err",       {31'd0, bus.out_err}, 32'd0);
        reset = 1'b1;
        #1 chk("rst.ready_before_edge", {31'd0, bus.in_ready}, 32'd0);
        @(negedge clk);
        chk("rst.ready_after_edge", {31'd0, bus.in_ready}, 32'd1);

        // Saturation boundaries and one-cycle latency
        beat(ADD, 100, 100, 1'b0);   expect_res("add_sat", 127, 1'b1, 1'b0);
        beat(SUB, -100, 100, 1'b0);  expect_res("sub_sat", -128, 1'b1, 1'b0);
        @(negedge clk);              expect_none("gap");
        beat(ADD, 3, 4, 1'b0);       expect_res("add_small", 7, 1'b0, 1'b0);

        // Back-to-back compare stream
        beat(MIN, -5, 3, 1'b0);      expect_res("min", -5, 1'b0, 1'b0);
        beat(MAX, -5, 3, 1'b0);      expect_res("max", 3, 1'b0, 1'b0);
        beat(EQ, 5, 5, 1'b0);        expect_res("eq_true", 1, 1'b0, 1'b0);
        beat(LT, -1, 1, 1'b0);       expect_res("lt_true", 1, 1'b0, 1'b0);
        beat(LT, 1, -1, 1'b0);       expect_res("lt_false", 0, 1'b0, 1'b0);
        beat(EQ, 5, 6, 1'b0);        expect_res("eq_false", 0, 1'b0, 1'b0);
        beat(NOOP, -77, 9, 1'b0);    expect_res("noop", -77, 1'b0, 1'b0);

        // Directed reductions
        q = '{10, 20, 30, 40};       column("sum4", SUM, q);
        q = '{1, 2, 3, 4, 5};        column("count5", COUNT, q);
        q = '{3, -7, 2};             column("rmin3", RMIN, q);
        q = '{100, 100, -50};        column("sum_sticky", SUM, q);
        q = {};
        for (int i = 0; i < 20; i++) q.push_back(i);
        column("count_sat", COUNT, q);

        // Backpressure: result held, input blocked, then simultaneous transfer
        @(negedge clk);
        bus.out_ready = 1'b0;
        beat(ADD, 20, 30, 1'b0);     expect_res("bp_first", 50, 1'b0, 1'b0);
        bus.cmd = SUB; bus.in1 = 8'd10; bus.in2 = 8'd4; bus.in_last = 1'b0;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("bp.in_ready", {31'd0, bus.in_ready}, 32'd0);
            chk("bp.out1",     {24'd0, bus.out1}, 32'd50);
            chk("bp.valid",    {31'd0, bus.out_valid}, 32'd1);
            @(negedge clk);
        end
        bus.out_ready = 1'b1;
        #1 chk("bp.release_ready", {31'd0, bus.in_ready}, 32'd1);
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        @(negedge clk);
        expect_res("bp_next", 6, 1'b0, 1'b0);

        // Reduction abort, then idle behaviour
        beat(SUM, 100, 0, 1'b0);     expect_none("abort.s1");
        beat(SUM, 100, 0, 1'b0);     expect_none("abort.s2");
        beat(ADD, 1, 2, 1'b0);       expect_res("abort", 0, 1'b0, 1'b1);
        beat(ADD, 1, 2, 1'b0);       expect_res("after_abort", 3, 1'b0, 1'b0);
        beat(4'hF, 1, 2, 1'b0);      expect_res("illegal_idle", 0, 1'b0, 1'b1);
        beat(RMAX, 3, 0, 1'b0);      expect_none("ill_red.s1");
        beat(4'h7, 3, 0, 1'b1);      expect_res("illegal_reduce", 0, 1'b0, 1'b1);
        beat(RMIN, 5, 0, 1'b1);      expect_res("single_rmin", 5, 1'b0, 1'b0);

        // Random single beats against the model
        for (int i = 0; i < 40; i++) begin
            c = 4'($urandom_range(0, 15));
            a = int'($urandom_range(0, 255)) - 128;
            b = int'($urandom_range(0, 255)) - 128;
            beat(c, a, b, is_reduction(c) ? 1'b1 : 1'($urandom_range(0, 1)));
            ref_single(c, a, b, r, o, e);
            expect_res("rand_beat", r, o, e);
        end

        // Random columns against the model
        for (int k = 0; k < 10; k++) begin
            c = 4'(8 + $urandom_range(0, 3));
            q = {};
            for (int i = 0; i < int'($urandom_range(1, 6)); i++)
                q.push_back(int'($urandom_range(0, 255)) - 128);
            column("rand_col", c, q);
        end

        // Reset in the middle of a SUM discards the partial result
        beat(SUM, 50, 0, 1'b0);      expect_none("mid.s1");
        beat(SUM, 60, 0, 1'b0);      expect_none("mid.s2");
        reset = 1'b0;
        #1;
        chk("mid.in_ready", {31'd0, bus.in_ready}, 32'd0);
        chk("mid.valid",    {31'd0, bus.out_valid}, 32'd0);
        chk("mid.out1",     {24'd0, bus.out1}, 32'd0);
        chk("mid.ovf",      {31'd0, bus.out_ovf}, 32'd0);
        chk("mid.err",      {31'd0, bus.out_err}, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        expect_none("mid.after");
        q = '{1, 2};                 column("fresh_sum", SUM, q);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
